// File: rtl/fifo_pkg.sv
// Shared types and defaults for the async-FIFO read-side stream adapter.
package fifo_pkg;

  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;

  typedef logic [DATASIZE-1:0] word_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  function automatic logic [1:0] occ_of(buf_state_e s);
    logic [1:0] occ;
    case (s)
      ONE:     occ = 2'd1;
      TWO:     occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry register buffer: head drives the stream, tail absorbs one extra word.
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int W = DATASIZE
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output buf_state_e   state_o
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_i) begin
            state_d = ONE;
            head_d  = din_i;
          end
        end
        ONE: begin
          case ({push_i, pop_i})
            2'b10: begin
              state_d = TWO;
              tail_d  = din_i;
            end
            2'b01: state_d = EMPTY;
            2'b11: head_d = din_i;
            default: ;
          endcase
        end
        TWO: begin
          if (pop_i) begin
            head_d = tail_q;
            if (push_i) tail_d = din_i;
            else state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign valid_o = (state_q != EMPTY);
  assign dout_o  = head_q;
  assign state_o = state_q;

  // The upstream credit scheme must never deliver a word into a full buffer.
  push_in_two_a: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && !flush_i && state_q == TWO));

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Async-FIFO read-side adapter: pops words into a 2-entry skid buffer and streams them out.
// Optional transfer/drop counters are enabled with `define FIFO_RD_STATS_EN.
module fifo_rd_stream_adapter #(
  parameter int DATASIZE   = fifo_pkg::DATASIZE,
  parameter int RD_LATENCY = 0
) (
  input  logic                rclk,
  input  logic                r_rst,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  input  logic                flush,
  output logic                m_valid,
  output logic [DATASIZE-1:0] m_data,
  input  logic                m_ready,
`ifdef FIFO_RD_STATS_EN
  output logic [15:0]         rd_count,
  output logic [7:0]          drop_count,
`endif
  output logic [1:0]          occupancy
);
  import fifo_pkg::*;

  // Stream handshake: a word transfers on every rclk edge where m_valid && m_ready;
  // m_data holds steady while m_valid=1 and m_ready=0.

  buf_state_e buf_state;
  logic       pop;
  logic       push;
  logic       discard;
  logic       room;

  assign pop = m_valid && m_ready;

  generate
    if (RD_LATENCY == 0) begin : g_lat0
      assign discard = 1'b0;
      assign push    = rinc && !discard;
      assign room    = (occupancy != 2'd2);
    end else if (RD_LATENCY == 1) begin : g_lat1
      logic inflight_q, inflight_d;
      assign inflight_d = rinc;
      always_ff @(posedge rclk) begin
        if (r_rst) inflight_q <= 1'b0;
        else       inflight_q <= inflight_d;
      end
      // A word arriving during a flush is dropped instead of entering the buffer.
      assign discard = inflight_q && flush;
      assign push    = inflight_q && !discard;
      // The slot freed by this cycle's transfer is reusable by the word issued now.
      assign room    = (({1'b0, occupancy} + {2'b00, inflight_q}) < 3'd2) || pop;
    end else begin : g_bad
      $error("fifo_rd_stream_adapter: RD_LATENCY must be 0 or 1");
      assign discard = 1'b0;
      assign push    = 1'b0;
      assign room    = 1'b0;
    end
  endgenerate

  assign rinc = !r_rst && !rempty && !flush && room;

  skid_buf2 #(.W(DATASIZE)) u_skid (
    .clk_i   (rclk),
    .rst_i   (r_rst),
    .push_i  (push),
    .din_i   (rdata),
    .pop_i   (pop),
    .flush_i (flush),
    .valid_o (m_valid),
    .dout_o  (m_data),
    .state_o (buf_state)
  );

  assign occupancy = occ_of(buf_state);

`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [7:0]  drop_count_q, drop_count_d;
  logic [8:0]  drop_sum;

  always_comb begin
    rd_count_d = rd_count_q;
    if (pop && rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
    drop_sum     = {1'b0, drop_count_q} + {7'b0, occupancy} + {8'b0, discard};
    drop_count_d = drop_count_q;
    if (flush) drop_count_d = (drop_sum > 9'h0FF) ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      rd_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      rd_count_q   <= rd_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign rd_count   = rd_count_q;
  assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: one adapter per read latency, each fed by its own FIFO model.
module tb_fifo_rd_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, m_ready, hold, inf_mode, sb_en, flush0, flush1;
  logic rinc0, rinc1, rempty0, rempty1, m_valid0, m_valid1;
  logic [7:0] rdata0, m_data0, m_data1;
  logic [7:0] rdata1 = 8'h00;
  logic [1:0] occ0, occ1;
`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count0, rd_count1;
  logic [7:0]  drop_count0, drop_count1;
`endif

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  int wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] e0, e1;
  int total = 0, bad = 0, cyc = 0;
  int xfer0 = 0, xfer1 = 0, first0 = -1, first1 = -1, last0 = 0, last1 = 0;

  fifo_rd_stream_adapter #(.DATASIZE(8), .RD_LATENCY(0)) u_l0 (
    .rclk(clk), .r_rst(rst), .rempty(rempty0), .rdata(rdata0), .rinc(rinc0),
    .flush(flush0), .m_valid(m_valid0), .m_data(m_data0), .m_ready(m_ready),
`ifdef FIFO_RD_STATS_EN
    .rd_count(rd_count0), .drop_count(drop_count0),
`endif
    .occupancy(occ0)
  );

  fifo_rd_stream_adapter #(.DATASIZE(8), .RD_LATENCY(1)) u_l1 (
    .rclk(clk), .r_rst(rst), .rempty(rempty1), .rdata(rdata1), .rinc(rinc1),
    .flush(flush1), .m_valid(m_valid1), .m_data(m_data1), .m_ready(m_ready),
`ifdef FIFO_RD_STATS_EN
    .rd_count(rd_count1), .drop_count(drop_count1),
`endif
    .occupancy(occ1)
  );

  // FIFO models: combinational read for u_l0, registered read for u_l1.
  assign rempty0 = hold || (!inf_mode && (rd0 == wr0));
  assign rempty1 = hold || (!inf_mode && (rd1 == wr1));
  assign rdata0  = mem0[rd0[7:0]];

  always @(posedge clk) begin
    if (rinc0 === 1'b1) rd0 <= rd0 + 1;
    if (rinc1 === 1'b1) begin
      rdata1 <= mem1[rd1[7:0]];
      rd1    <= rd1 + 1;
    end
  end

  // Scoreboard: every accepted transfer must match the next expected word.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sb_en && !rst && m_valid0 && m_ready) begin
      total++;
      if (exp_q0.size() == 0) begin
        bad++; $display("FAIL sb_l0 unexpected word got=%h", m_data0);
      end else begin
        e0 = exp_q0.pop_front();
        if (m_data0 !== e0) begin bad++; $display("FAIL sb_l0 data got=%h exp=%h", m_data0, e0); end
      end
      xfer0++; if (first0 < 0) first0 = cyc; last0 = cyc;
    end
    if (sb_en && !rst && m_valid1 && m_ready) begin
      total++;
      if (exp_q1.size() == 0) begin
        bad++; $display("FAIL sb_l1 unexpected word got=%h", m_data1);
      end else begin
        e1 = exp_q1.pop_front();
        if (m_data1 !== e1) begin bad++; $display("FAIL sb_l1 data got=%h exp=%h", m_data1, e1); end
      end
      xfer1++; if (first1 < 0) first1 = cyc; last1 = cyc;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load(input int n, input logic [7:0] base);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = base + 8'(i);
      mem0[wr0[7:0]] = v; wr0++; exp_q0.push_back(v);
      mem1[wr1[7:0]] = v; wr1++; exp_q1.push_back(v);
    end
  endtask

  task automatic clr_xfer();
    xfer0 = 0; xfer1 = 0; first0 = -1; first1 = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b0; hold = 1'b0;
    load(1, 8'h11);
    repeat (3) tick();
    @(negedge clk);
    total++; if (rinc0 !== 1'b0) begin bad++; $display("FAIL rst_rinc0 got=%b exp=0", rinc0); end
    total++; if (rinc1 !== 1'b0) begin bad++; $display("FAIL rst_rinc1 got=%b exp=0", rinc1); end
    total++; if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b exp=00", m_valid0, m_valid1); end
    total++; if (occ0 !== 2'd0 || occ1 !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d/%0d exp=0/0", occ0, occ1); end
    total++; if (m_data0 !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", m_data0); end
    tick(); rst = 1'b0;
    @(negedge clk);
    total++; if (rinc0 !== 1'b1 || rinc1 !== 1'b1) begin bad++; $display("FAIL first_rinc got=%b%b exp=11", rinc0, rinc1); end
    tick(); @(negedge clk);
    total++; if (m_valid0 !== 1'b1 || m_data0 !== 8'h11) begin bad++; $display("FAIL first_word_l0 got=%b/%h exp=1/11", m_valid0, m_data0); end
    total++; if (occ0 !== 2'd1 || rinc0 !== 1'b0) begin bad++; $display("FAIL after_first_l0 occ=%0d rinc=%b exp=1/0", occ0, rinc0); end
    total++; if (m_valid1 !== 1'b0) begin bad++; $display("FAIL first_word_l1_early got=%b exp=0", m_valid1); end
    tick(); @(negedge clk);
    total++; if (m_valid1 !== 1'b1 || m_data1 !== 8'h11) begin bad++; $display("FAIL first_word_l1 got=%b/%h exp=1/11", m_valid1, m_data1); end
    tick(); m_ready = 1'b1;
    repeat (3) tick();
    total++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin bad++; $display("FAIL reset_drain left=%0d/%0d exp=0/0", exp_q0.size(), exp_q1.size()); end
  endtask

  task automatic test_stream();
    m_ready = 1'b1; clr_xfer();
    load(64, 8'h00);
    repeat (80) tick();
    total++; if (xfer0 != 64 || xfer1 != 64) begin bad++; $display("FAIL stream_count got=%0d/%0d exp=64/64", xfer0, xfer1); end
    total++; if (last0 - first0 != 63) begin bad++; $display("FAIL stream_gap_l0 span=%0d exp=63", last0 - first0); end
    total++; if (last1 - first1 != 63) begin bad++; $display("FAIL stream_gap_l1 span=%0d exp=63", last1 - first1); end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0; clr_xfer();
    load(8, 8'h40);
    repeat (10) tick();
    @(negedge clk);
    total++; if (occ0 !== 2'd2 || occ1 !== 2'd2) begin bad++; $display("FAIL bp_occ got=%0d/%0d exp=2/2", occ0, occ1); end
    total++; if (rinc0 !== 1'b0 || rinc1 !== 1'b0) begin bad++; $display("FAIL bp_rinc got=%b%b exp=00", rinc0, rinc1); end
    total++; if (m_valid0 !== 1'b1 || m_data0 !== 8'h40) begin bad++; $display("FAIL bp_hold_l0 got=%b/%h exp=1/40", m_valid0, m_data0); end
    total++; if (m_valid1 !== 1'b1 || m_data1 !== 8'h40) begin bad++; $display("FAIL bp_hold_l1 got=%b/%h exp=1/40", m_valid1, m_data1); end
    tick(); m_ready = 1'b1;
    repeat (15) tick();
    total++; if (xfer0 != 8 || xfer1 != 8) begin bad++; $display("FAIL bp_drain got=%0d/%0d exp=8/8", xfer0, xfer1); end
  endtask

  task automatic test_empty();
    m_ready = 1'b1; clr_xfer();
    load(3, 8'h50);
    repeat (8) begin
      tick(); @(negedge clk);
      total++; if ((rinc0 && rempty0) || (rinc1 && rempty1)) begin bad++; $display("FAIL empty_rinc got=%b%b exp=00", rinc0, rinc1); end
    end
    total++; if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0) begin bad++; $display("FAIL empty_valid got=%b%b exp=00", m_valid0, m_valid1); end
    total++; if (xfer0 != 3 || xfer1 != 3) begin bad++; $display("FAIL empty_count got=%0d/%0d exp=3/3", xfer0, xfer1); end
    hold = 1'b1;
    load(1, 8'h53);
    repeat (4) begin
      tick(); @(negedge clk);
      total++; if (rinc0 !== 1'b0 || rinc1 !== 1'b0) begin bad++; $display("FAIL held_rinc got=%b%b exp=00", rinc0, rinc1); end
    end
    tick(); hold = 1'b0;
    repeat (5) tick();
    total++; if (xfer0 != 4 || xfer1 != 4) begin bad++; $display("FAIL refill_count got=%0d/%0d exp=4/4", xfer0, xfer1); end
  endtask

  task automatic test_flush();
    m_ready = 1'b0; clr_xfer();
    tick();
    load(4, 8'h60);
    tick(); tick();
    flush1 = 1'b1;
    @(negedge clk);
    total++; if (occ1 !== 2'd1 || m_data1 !== 8'h60) begin bad++; $display("FAIL pre_flush occ=%0d data=%h exp=1/60", occ1, m_data1); end
    total++; if (rinc1 !== 1'b0) begin bad++; $display("FAIL flush_rinc got=%b exp=0", rinc1); end
    tick(); flush1 = 1'b0;
    @(negedge clk);
    total++; if (m_valid1 !== 1'b0 || occ1 !== 2'd0) begin bad++; $display("FAIL post_flush valid=%b occ=%0d exp=0/0", m_valid1, occ1); end
    total++; if (rinc1 !== 1'b1) begin bad++; $display("FAIL post_flush_rinc got=%b exp=1", rinc1); end
`ifdef FIFO_RD_STATS_EN
    total++; if (drop_count1 !== 8'd2) begin bad++; $display("FAIL drop_count got=%0d exp=2", drop_count1); end
`endif
    void'(exp_q1.pop_front());
    void'(exp_q1.pop_front());
    tick(); @(negedge clk);
    total++; if (m_valid1 !== 1'b0) begin bad++; $display("FAIL inflight_leak got=%b/%h exp=0", m_valid1, m_data1); end
    tick(); @(negedge clk);
    total++; if (m_valid1 !== 1'b1 || m_data1 !== 8'h62) begin bad++; $display("FAIL after_flush got=%b/%h exp=1/62", m_valid1, m_data1); end
    tick(); m_ready = 1'b1;
    repeat (12) tick();
    total++; if (xfer0 != 4 || xfer1 != 2) begin bad++; $display("FAIL flush_drain got=%0d/%0d exp=4/2", xfer0, xfer1); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0; clr_xfer();
    tick();
    load(4, 8'h70);
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    total++; if (rinc0 !== 1'b0 || rinc1 !== 1'b0) begin bad++; $display("FAIL mid_rst_rinc got=%b%b exp=00", rinc0, rinc1); end
    tick(); @(negedge clk);
    total++; if (m_valid0 !== 1'b0 || m_valid1 !== 1'b0 || occ0 !== 2'd0 || occ1 !== 2'd0) begin
      bad++; $display("FAIL mid_rst_clear valid=%b%b occ=%0d/%0d exp=00 0/0", m_valid0, m_valid1, occ0, occ1);
    end
    tick(); rst = 1'b0;
    repeat (2) begin void'(exp_q0.pop_front()); void'(exp_q1.pop_front()); end
    m_ready = 1'b1;
    repeat (10) tick();
    total++; if (xfer0 != 2 || xfer1 != 2) begin bad++; $display("FAIL mid_rst_resume got=%0d/%0d exp=2/2", xfer0, xfer1); end
    total++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin bad++; $display("FAIL mid_rst_left got=%0d/%0d exp=0/0", exp_q0.size(), exp_q1.size()); end
  endtask

`ifdef FIFO_RD_STATS_EN
  task automatic test_stats();
    m_ready = 1'b0;
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    total++; if (rd_count0 !== 16'd0 || rd_count1 !== 16'd0) begin bad++; $display("FAIL stats_clr got=%h/%h exp=0/0", rd_count0, rd_count1); end
    sb_en = 1'b0; inf_mode = 1'b1; m_ready = 1'b1;
    repeat (70010) tick();
    total++; if (rd_count0 !== 16'hFFFF || rd_count1 !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h/%h exp=ffff", rd_count0, rd_count1); end
    m_ready = 1'b0; rst = 1'b1;
    tick(); @(negedge clk);
    total++; if (rd_count0 !== 16'd0 || rd_count1 !== 16'd0) begin bad++; $display("FAIL stats_rst got=%h/%h exp=0/0", rd_count0, rd_count1); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; m_ready = 1'b0; hold = 1'b0; inf_mode = 1'b0; sb_en = 1'b1;
    flush0 = 1'b0; flush1 = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty();
    test_flush();
    test_reset_mid();
`ifdef FIFO_RD_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
